// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN,
        LU_STALL
    } state_e;

    localparam int unsigned REG_ZERO       = 0;
    localparam int unsigned LOAD_STALL_MIN = 1;
    localparam int unsigned LOAD_STALL_MAX = 4;

    function automatic bit load_stall_legal(input int unsigned n);
        return (n >= LOAD_STALL_MIN) && (n <= LOAD_STALL_MAX);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard inputs and pipeline-register control outputs of hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_rs_use_i;
    logic             id_rt_use_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rt_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_nop_o;
    logic             id_ex_write_o;
    logic             ex_mem_write_o;
    logic             mem_wb_nop_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] mem_wait_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i, ex_memread_i, ex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_nop_o, id_ex_write_o,
               ex_mem_write_o, mem_wb_nop_o, lu_stall_cnt_o, mem_wait_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i, ex_memread_i, ex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_nop_o, id_ex_write_o,
               ex_mem_write_o, mem_wb_nop_o, lu_stall_cnt_o, mem_wait_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, memory freeze and branch flush control for the 5-stage pipeline.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);
    if (!load_stall_legal(LOAD_STALL)) begin : g_bad_load_stall
        $error("hazard_ctrl: LOAD_STALL out of range 1..4");
    end

    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);
    localparam logic [1:0]       REM_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

    state_e     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       haz, frz, stall_act;

    assign haz = bus.ex_memread_i && (bus.ex_rt_i != ZERO_REG) &&
                 ((bus.id_rs_use_i && (bus.id_rs_i == bus.ex_rt_i)) ||
                  (bus.id_rt_use_i && (bus.id_rt_i == bus.ex_rt_i)));
    assign frz       = bus.dmem_req_i && !bus.dmem_ready_i;
    assign stall_act = !frz && ((state_q == LU_STALL) || haz);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // The first bubble is issued from RUN, so LU_STALL only covers the remaining LOAD_STALL-1.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!frz) begin
            unique case (state_q)
                RUN: begin
                    if (haz && (LOAD_STALL > 1)) begin
                        state_d = LU_STALL;
                        rem_d   = REM_INIT;
                    end
                end
                LU_STALL: begin
                    if (rem_q == '0) begin
                        state_d = RUN;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        bus.pc_write_o     = 1'b1;
        bus.if_id_write_o  = 1'b1;
        bus.if_id_flush_o  = bus.branch_taken_i;
        bus.id_ex_nop_o    = 1'b0;
        bus.id_ex_write_o  = 1'b1;
        bus.ex_mem_write_o = 1'b1;
        bus.mem_wb_nop_o   = 1'b0;
        if (rst_i) begin
            if (frz) begin
                bus.pc_write_o     = 1'b0;
                bus.if_id_write_o  = 1'b0;
                bus.if_id_flush_o  = 1'b0;
                bus.id_ex_write_o  = 1'b0;
                bus.ex_mem_write_o = 1'b0;
                bus.mem_wb_nop_o   = 1'b1;
            end else if (stall_act) begin
                bus.pc_write_o    = 1'b0;
                bus.if_id_write_o = 1'b0;
                bus.if_id_flush_o = 1'b0;
                bus.id_ex_nop_o   = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (rst_i && stall_act),
        .count (bus.lu_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (rst_i && frz),
        .count (bus.mem_wait_cnt_o)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl (LOAD_STALL=1/CNT_W=32 and LOAD_STALL=3/CNT_W=4).
module tb_hazard_ctrl;
    localparam int unsigned LA = 1;
    localparam int unsigned WA = 32;
    localparam int unsigned LB = 3;
    localparam int unsigned WB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs = '0, rt = '0, ert = '0;
    logic       rsu = 1'b0, rtu = 1'b0, memrd = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(WA)) ifa ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(WB)) ifb ();

    assign ifa.id_rs_i = rs;     assign ifb.id_rs_i = rs;
    assign ifa.id_rt_i = rt;     assign ifb.id_rt_i = rt;
    assign ifa.id_rs_use_i = rsu; assign ifb.id_rs_use_i = rsu;
    assign ifa.id_rt_use_i = rtu; assign ifb.id_rt_use_i = rtu;
    assign ifa.ex_memread_i = memrd; assign ifb.ex_memread_i = memrd;
    assign ifa.ex_rt_i = ert;    assign ifb.ex_rt_i = ert;
    assign ifa.branch_taken_i = br; assign ifb.branch_taken_i = br;
    assign ifa.dmem_req_i = req; assign ifb.dmem_req_i = req;
    assign ifa.dmem_ready_i = rdy; assign ifb.dmem_ready_i = rdy;

    hazard_ctrl #(.REG_W(5), .LOAD_STALL(LA), .CNT_W(WA)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (ifa)
    );
    hazard_ctrl #(.REG_W(5), .LOAD_STALL(LB), .CNT_W(WB)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (ifb)
    );

    typedef struct {
        logic [6:0] ca;
        longint     lua, mwa;
        logic [6:0] cb;
        longint     lub, mwb;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: bubbles still owed after the current one, plus counter values.
    int     left_a = 0, left_b = 0;
    longint lu_a = 0, mw_a = 0, lu_b = 0, mw_b = 0;

    function automatic logic [6:0] model_ctrl(input bit r, input bit h, input bit f,
                                              input bit b, input int left);
        if (r && f)               return 7'b0000001;
        if (r && (left > 0 || h)) return 7'b0001110;
        return {1'b1, 1'b1, b, 1'b0, 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic model_next(input bit r, input bit h, input bit f, input int L,
                              input int W, inout int left, inout longint lu, inout longint mw);
        longint mx;
        mx = (longint'(1) << W) - 1;
        if (!r) begin
            left = 0; lu = 0; mw = 0;
        end else if (f) begin
            if (mw < mx) mw++;
        end else if (left > 0) begin
            left--;
            if (lu < mx) lu++;
        end else if (h) begin
            left = L - 1;
            if (lu < mx) lu++;
        end
    endtask

    task automatic drive(input bit r, input bit mr, input int er, input int irs,
                         input int irt, input bit ru, input bit tu, input bit b,
                         input bit q, input bit y);
        exp_t e;
        bit   h, f;
        @(posedge clk);
        #1;
        rst = r; memrd = mr; ert = 5'(er); rs = 5'(irs); rt = 5'(irt);
        rsu = ru; rtu = tu; br = b; req = q; rdy = y;
        h = mr && (er != 0) && ((ru && irs == er) || (tu && irt == er));
        f = q && !y;
        e.ca = model_ctrl(r, h, f, b, left_a); e.lua = lu_a; e.mwa = mw_a;
        e.cb = model_ctrl(r, h, f, b, left_b); e.lub = lu_b; e.mwb = mw_b;
        sb.push_back(e);
        model_next(r, h, f, LA, WA, left_a, lu_a, mw_a);
        model_next(r, h, f, LB, WB, left_b, lu_b, mw_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ctrl_a", {ifa.pc_write_o, ifa.if_id_write_o, ifa.if_id_flush_o, ifa.id_ex_nop_o,
                           ifa.id_ex_write_o, ifa.ex_mem_write_o, ifa.mem_wb_nop_o}, e.ca);
            chk("lu_cnt_a", ifa.lu_stall_cnt_o, e.lua);
            chk("mw_cnt_a", ifa.mem_wait_cnt_o, e.mwa);
            chk("ctrl_b", {ifb.pc_write_o, ifb.if_id_write_o, ifb.if_id_flush_o, ifb.id_ex_nop_o,
                           ifb.id_ex_write_o, ifb.ex_mem_write_o, ifb.mem_wb_nop_o}, e.cb);
            chk("lu_cnt_b", ifb.lu_stall_cnt_o, e.lub);
            chk("mw_cnt_b", ifb.mem_wait_cnt_o, e.mwb);
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // lw $2 then add $3,$2,$4
        drive(1, 1, 2, 2, 4, 1, 1, 0, 0, 0);
        idle(4);
        // load to $0, and rt match with rt unused
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 5, 1, 5, 1, 0, 0, 0, 0);
        idle(2);
        // freeze of two cycles landing in the second bubble
        drive(1, 1, 2, 2, 4, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        // hazard with branch, then branch alone
        drive(1, 1, 7, 7, 0, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // haz and frz together: freeze wins, haz seen after release
        drive(1, 1, 3, 3, 0, 1, 0, 0, 1, 0);
        drive(1, 1, 3, 3, 0, 1, 0, 0, 0, 0);
        idle(3);
        // build counts, then reset mid-stall
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 6, 0, 6, 0, 1, 0, 0, 0);
            idle(3);
        end
        drive(1, 1, 6, 6, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // long freeze saturates the 4-bit counter
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
            idle(2);
        end
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage and driving the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register controls. It detects load-use hazards with a configurable bubble count and suppresses false stalls on unused operands and on `$0`. It also freezes the whole pipeline while the data memory is busy and flushes IF/ID on taken branches. Two saturating performance counters report inserted bubbles and memory-wait cycles.

## Interface
Parameters:
- `REG_W`, 5: register-address width.
- `LOAD_STALL`, 1: bubbles inserted per load-use hazard; legal range 1..4.
- `CNT_W`, 32: performance-counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `id_rs_i`, `id_rt_i`  in  REG_W each  source registers of the instruction in ID.
- `id_rs_use_i`, `id_rt_use_i`  in  1 each  the corresponding source is actually read.
- `ex_memread_i`  in  1  the instruction in EX is a load.
- `ex_rt_i`  in  REG_W  destination register of the load in EX.
- `branch_taken_i`  in  1  branch resolved taken in ID this cycle.
- `dmem_req_i`  in  1  MEM stage is issuing a data-memory access.
- `dmem_ready_i`  in  1  data memory completes the access this cycle.
- `pc_write_o`  out  1  PC write enable.
- `if_id_write_o`  out  1  IF/ID write enable.
- `if_id_flush_o`  out  1  IF/ID loads a NOP.
- `id_ex_nop_o`  out  1  ID/EX loads a bubble.
- `id_ex_write_o`  out  1  ID/EX write enable.
- `ex_mem_write_o`  out  1  EX/MEM write enable.
- `mem_wb_nop_o`  out  1  MEM/WB loads a bubble.
- `lu_stall_cnt_o`  out  CNT_W  load-use bubbles inserted.
- `mem_wait_cnt_o`  out  CNT_W  memory-freeze cycles.

## Operation
- Hazard term `haz` = `ex_memread_i` & (`ex_rt_i` != 0) & ((`id_rs_use_i` & `id_rs_i` == `ex_rt_i`) | (`id_rt_use_i` & `id_rt_i` == `ex_rt_i`)).
- Freeze term `frz` = `dmem_req_i` & ~`dmem_ready_i`.
- Per-cycle action, in priority order; the first term that holds decides the outputs:
  1. `frz`: freeze. `pc_write_o`, `if_id_write_o`, `id_ex_write_o` and `ex_mem_write_o` are 0; `mem_wb_nop_o`=1; `id_ex_nop_o`=0; `if_id_flush_o`=0. The FSM state and the bubble counter hold.
  2. Stall (state LU_STALL, or state RUN with `haz`): `pc_write_o`=0, `if_id_write_o`=0, `id_ex_nop_o`=1. `branch_taken_i` is ignored.
  3. Run: all write enables are 1 and all nop/flush outputs are 0, except `if_id_flush_o` = `branch_taken_i`.
- FSM states, advanced only when `frz`=0:
  - RUN: if `haz` and `LOAD_STALL`>1, go to LU_STALL with `rem` = `LOAD_STALL`-2. Otherwise stay in RUN.
  - LU_STALL: if `rem`=0, go to RUN; otherwise decrement `rem`.
  - In LU_STALL, `haz` is not re-evaluated.
- Total bubbles per hazard = `LOAD_STALL`, with the first bubble in the same cycle `haz` rises.
- `lu_stall_cnt_o` increments in every stall-action cycle.
- `mem_wait_cnt_o` increments in every freeze cycle.
- Both counters saturate at all-ones; they do not wrap.

## Timing
- Hazard and freeze responses are combinational: zero-cycle latency from the inputs to the control outputs.
- State, `rem` and both counters are registered.
- Reset (`rst_i`=0 at a rising edge): state becomes RUN, `rem`=0, both counters become 0. This applies equally when reset arrives mid-stall or mid-freeze.
- While `rst_i`=0, the outputs follow the run action using the live inputs, and no counting occurs.
- A freeze during LU_STALL extends the stall: the bubble count is unchanged and the remaining stall resumes after the freeze ends.
- `haz` and `frz` in the same RUN cycle: freeze wins. `haz` is re-evaluated once the freeze releases.
- `dmem_req_i` with `dmem_ready_i` both 1: no freeze.

## Structure
- Package `hazard_pkg` holds:
  - the state enum {RUN, LU_STALL};
  - the constant for the `$0` register address;
  - the legal `LOAD_STALL` bounds, with an elaboration-time check on the parameter.
- One sub-module, `sat_counter` (parameter W; ports inc, count), instantiated twice for the two performance counters.

## Test plan
- Load `$2`, then `add $3,$2,$4`, `LOAD_STALL`=1 → exactly one cycle with `id_ex_nop_o`=1, `pc_write_o`=0, `if_id_write_o`=0; then `lu_stall_cnt_o`=1.
- Same sequence with `LOAD_STALL`=3 → three consecutive bubble cycles, then RUN; `lu_stall_cnt_o`=3.
- Load `$0`, or matching `id_rt_i` with `id_rt_use_i`=0 → no stall and the counter stays 0.
- `LOAD_STALL`=3, a freeze of 2 cycles starting in the second bubble → 2 freeze cycles, then the remaining bubble; counters read 3 and 2.
- `haz`=1 with `branch_taken_i`=1 → `if_id_flush_o`=0 and stall applied. Next cycle, with `haz`=0 and the branch still taken → `if_id_flush_o`=1.
- Reset asserted during LU_STALL with counters at 5 → next cycle is state RUN with counters 0. Counter preloaded to all-ones with `CNT_W`=4 → stays at 15.
